id_gen: RTL and testbench

ID_GEN -- requirements
Module: id_gen

---
 rtl/id_gen_if.sv | 21 ++
 rtl/id_gen.sv | 138 +++++++++++++
 tb/tb_id_gen.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/id_gen_if.sv
// Handshake bundle for the identifier generator: token request in, character stream out.
interface id_gen_if;
    logic       start;
    logic [3:0] letters;
    logic [3:0] digits;
    logic       ready;
    logic [7:0] char;
    logic       valid;
    logic       busy;
    logic       done;

    modport master (
        output start, letters, digits, ready,
        input  char, valid, busy, done
    );

    modport slave (
        input  start, letters, digits, ready,
        output char, valid, busy, done
    );
endinterface

// File: rtl/id_gen.sv
// Pseudo-random identifier generator: emits L letters, D digits and a separator per token,
// one registered character per valid/ready handshake, driven by a 16-bit Fibonacci LFSR.
module id_gen #(
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter logic [7:0]  SEP_CHAR = 8'd32
) (
    input  logic     clk,
    input  logic     reset,
    id_gen_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LET  = 3'd1,
        DIG  = 3'd2,
        SEP  = 3'd3,
        FIN  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [7:0]  char_q, char_d;
    logic        valid_q, valid_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  dlat_q, dlat_d;
    logic [15:0] lfsr_adv;
    logic        hs;

    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    // Bit 5 picks the case, bits 4:0 folded into the 26-letter range.
    function automatic logic [7:0] letter_of(input logic [5:0] q);
        logic [4:0] i;
        i = q[4:0];
        if (i >= 5'd26) i = i - 5'd26;
        return q[5] ? (8'h41 + {3'b000, i}) : (8'h61 + {3'b000, i});
    endfunction

    function automatic logic [7:0] digit_of(input logic [3:0] q);
        logic [3:0] k;
        k = q;
        if (k >= 4'd10) k = k - 4'd10;
        return 8'h30 + {4'b0000, k};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            char_q  <= 8'h00;
            valid_q <= 1'b0;
            cnt_q   <= 4'd0;
            dlat_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            char_q  <= char_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            dlat_q  <= dlat_d;
        end
    end

    // Next char is always built from the post-step LFSR so handshakes can run back to back.
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        char_d   = char_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        dlat_d   = dlat_q;
        lfsr_adv = lfsr_step(lfsr_q);
        hs       = valid_q & bus.ready;

        case (state_q)
            IDLE: begin
                if (bus.start && (bus.letters != 4'd0)) begin
                    state_d = LET;
                    cnt_d   = bus.letters;
                    dlat_d  = bus.digits;
                    valid_d = 1'b1;
                    char_d  = letter_of(lfsr_q[5:0]);
                end
            end
            LET: begin
                if (hs) begin
                    lfsr_d = lfsr_adv;
                    if (cnt_q == 4'd1) begin
                        if (dlat_q != 4'd0) begin
                            state_d = DIG;
                            cnt_d   = dlat_q;
                            char_d  = digit_of(lfsr_adv[3:0]);
                        end else begin
                            state_d = SEP;
                            char_d  = SEP_CHAR;
                        end
                    end else begin
                        cnt_d  = cnt_q - 4'd1;
                        char_d = letter_of(lfsr_adv[5:0]);
                    end
                end
            end
            DIG: begin
                if (hs) begin
                    lfsr_d = lfsr_adv;
                    if (cnt_q == 4'd1) begin
                        state_d = SEP;
                        char_d  = SEP_CHAR;
                    end else begin
                        cnt_d  = cnt_q - 4'd1;
                        char_d = digit_of(lfsr_adv[3:0]);
                    end
                end
            end
            SEP: begin
                if (hs) begin
                    state_d = FIN;
                    valid_d = 1'b0;
                    char_d  = 8'h00;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.char  = char_q;
    assign bus.valid = valid_q;
    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = (state_q == FIN);

endmodule

// File: tb/tb_id_gen.sv
// Directed bench for id_gen: table of tokens with hand-computed characters from SEED 16'hACE1,
// plus hand-written sequences for ignored starts and reset mid-token.
module tb_id_gen;

    typedef struct packed {
        logic        doReset;
        logic [3:0]  l;
        logic [3:0]  d;
        logic        stall;
        logic        poke;
        logic        classOnly;
        logic [47:0] exp;
    } vec_t;

    logic clk;
    logic reset;
    int   checkCount;
    int   passCount;

    id_gen_if bus ();

    id_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got hang, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [7:0] act,
                               input logic [7:0] exp, output bit ok);
        checkCount++;
        ok = (act === exp);
        if (ok) passCount++;
        else $display("[TB] FAIL %s: got 8'h%02h, expected 8'h%02h", name, act, exp);
    endtask

    // kind: 0 letter, 1 digit, 2 separator
    task automatic checkClass(input logic [7:0] c, input int kind, output bit ok);
        checkCount++;
        case (kind)
            0:       ok = ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
            1:       ok = (c >= 8'h30) && (c <= 8'h39);
            default: ok = (c === 8'h20);
        endcase
        if (ok) passCount++;
        else $display("[TB] FAIL charClass: got 8'h%02h, expected class %0d (0=letter,1=digit,2=sep)", c, kind);
    endtask

    task automatic doReset();
        @(negedge clk);
        bus.start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        int n, idx, cyc, kind;
        bit ok, okv;
        n = int'(v.l) + int'(v.d) + 1;
        if (v.doReset) doReset();
        @(negedge clk);
        bus.start   = 1'b1;
        bus.letters = v.l;
        bus.digits  = v.d;
        bus.ready   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        idx = 0;
        cyc = 0;
        ok  = 1'b1;
        while ((idx < n) && (cyc < 120) && ok) begin
            checkOutput("valid", {7'b0, bus.valid}, 8'h01, okv);
            if (v.classOnly) begin
                kind = (idx < int'(v.l)) ? 0 : ((idx < n - 1) ? 1 : 2);
                checkClass(bus.char, kind, ok);
            end else begin
                checkOutput("char", bus.char, v.exp[47 - 8*idx -: 8], ok);
            end
            ok = ok && okv;
            bus.ready   = v.stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            bus.start   = v.poke && (cyc == 1);
            bus.letters = (v.poke && (cyc == 1)) ? 4'd2 : v.l;
            bus.digits  = (v.poke && (cyc == 1)) ? 4'd3 : v.d;
            if (bus.valid && bus.ready) idx++;
            cyc++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.ready = 1'b1;
        if (idx < n) begin
            checkCount++;
            $display("[TB] FAIL token: got %0d chars accepted, expected %0d", idx, n);
            doReset();
        end else begin
            checkOutput("doneFin",  {7'b0, bus.done},  8'h01, ok);
            checkOutput("validFin", {7'b0, bus.valid}, 8'h00, ok);
            checkOutput("busyFin",  {7'b0, bus.busy},  8'h01, ok);
            @(negedge clk);
            checkOutput("doneAfter", {7'b0, bus.done}, 8'h00, ok);
            checkOutput("busyAfter", {7'b0, bus.busy}, 8'h00, ok);
            @(negedge clk);
            checkOutput("noSecondToken", {6'b0, bus.busy, bus.valid}, 8'h00, ok);
        end
    endtask

    vec_t vectors [0:6];
    vec_t v;
    bit   ok;

    initial begin
        // Expected chars from SEED: LFSR ACE1,59C3,B387,670F,CE1E -> letters B,d,h,p,e; digits 1,3,7,5,4
        vectors[0] = '{1'b1, 4'd1,  4'd0,  1'b0, 1'b0, 1'b0, 48'h4220_0000_0000};
        vectors[1] = '{1'b0, 4'd1,  4'd1,  1'b0, 1'b0, 1'b0, 48'h6437_2000_0000};
        vectors[2] = '{1'b1, 4'd3,  4'd2,  1'b0, 1'b0, 1'b0, 48'h4264_6835_3420};
        vectors[3] = '{1'b1, 4'd2,  4'd2,  1'b0, 1'b0, 1'b0, 48'h4264_3735_2000};
        vectors[4] = '{1'b1, 4'd2,  4'd2,  1'b1, 1'b0, 1'b0, 48'h4264_3735_2000};
        vectors[5] = '{1'b1, 4'd4,  4'd1,  1'b0, 1'b1, 1'b0, 48'h4264_6870_3420};
        vectors[6] = '{1'b1, 4'd15, 4'd15, 1'b0, 1'b0, 1'b1, 48'h0};

        checkCount  = 0;
        passCount   = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.letters = 4'd0;
        bus.digits  = 4'd0;
        bus.ready   = 1'b1;
        #3;
        checkOutput("rstValid", {7'b0, bus.valid}, 8'h00, ok);
        checkOutput("rstChar",  bus.char,          8'h00, ok);
        checkOutput("rstBusy",  {7'b0, bus.busy},  8'h00, ok);
        checkOutput("rstDone",  {7'b0, bus.done},  8'h00, ok);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) applyStimulus(vectors[i]);

        // letters=0 requests are dropped
        @(negedge clk);
        bus.start   = 1'b1;
        bus.letters = 4'd0;
        bus.digits  = 4'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("zeroLetBusy",  {7'b0, bus.busy},  8'h00, ok);
            checkOutput("zeroLetValid", {7'b0, bus.valid}, 8'h00, ok);
        end
        bus.start = 1'b0;

        // Reset in DIG: L=1, D=2; second char is digit from 16'h59C3 -> '3'
        doReset();
        @(negedge clk);
        bus.start   = 1'b1;
        bus.letters = 4'd1;
        bus.digits  = 4'd2;
        bus.ready   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("digLetter", bus.char, 8'h42, ok);
        @(negedge clk);
        checkOutput("digChar", bus.char,         8'h33, ok);
        checkOutput("digBusy", {7'b0, bus.busy}, 8'h01, ok);
        #2 reset = 1'b1;
        #1;
        checkOutput("asyncValid", {7'b0, bus.valid}, 8'h00, ok);
        checkOutput("asyncBusy",  {7'b0, bus.busy},  8'h00, ok);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("noDoneAfterRst", {6'b0, bus.done, bus.valid}, 8'h00, ok);
        end
        v = '{1'b0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 48'h4220_0000_0000};
        applyStimulus(v);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
